// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch channel between the PC sequencer (master) and
// instruction memory (slave): request/address out, acknowledge/data back.
interface pc_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, fetches over a req/ack channel and
// commits the resolved next PC (sequential, branch, jump or register jump).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr_o,
  output logic                  instr_valid_o,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_plus4_o,
  input  logic                  ctrl_valid_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  input  logic                  jr_i,
  input  logic [15:0]           immediate_i,
  input  logic [25:0]           jump_index_i,
  input  logic [31:0]           jr_target_i,
  output logic [31:0]           retired_o,
  output logic                  align_err_o
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        instr_valid_q, instr_valid_d;
  logic        align_err_q, align_err_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        commit;
  logic        jr_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {{14{immediate_i[15]}}, immediate_i, 2'b00};
  assign jump_target   = {pc_plus4[31:28], jump_index_i, 2'b00};
  assign jr_misaligned = jr_i && (jr_target_i[1:0] != 2'b00);
  assign commit        = (state_q == EXEC) && ctrl_valid_i && !stall_i;

  // Register jump dominates, then absolute jump, then taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jr_i) begin
      next_pc = jr_target_i;
    end else if (jump_i) begin
      next_pc = jump_target;
    end else if (branch_taken_i) begin
      next_pc = branch_target;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    instr_valid_d = 1'b0;
    align_err_d   = align_err_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.ack) begin
          instr_d       = imem.rdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          if (jr_misaligned) begin
            align_err_d = 1'b1;
            state_d     = HALT;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
            state_d   = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      retired_q     <= 32'd0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
      align_err_q   <= align_err_d;
    end
  end

  // Request is a pure function of state, so address stays stable until ack.
  assign imem.req      = (state_q == FETCH);
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign retired_o     = retired_q;
  assign align_err_o   = align_err_q;

endmodule
